// File: rtl/add_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package add_sched_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_W = 2;

  typedef enum logic [1:0] {IDLE, CALC, RESP} sched_state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/add_reg.sv
// Registered W-bit adder; sum wraps modulo 2^W and only updates when enabled.
module add_reg #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  always_ff @(posedge clk) begin
    if (rst)     sum <= '0;
    else if (en) sum <= a + b;
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);
  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/add_rr_scheduler.sv
// Shares one registered adder among N requesters with round-robin grant and
// a single backpressured response channel; at most one operation in flight.
module add_rr_scheduler
  import add_sched_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_sum,
  output logic [IDW-1:0] rsp_id,
  output logic           busy
);
  sched_state_t   state, state_nxt;
  logic [IDW-1:0] rr_ptr, id_q, grant_idx;
  logic [N-1:0]   grant;
  logic           any;
  logic [W-1:0]   op_a, op_b, sel_a, sel_b;
  logic           launch;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .grant(grant), .grant_idx(grant_idx), .any(any)
  );

  add_reg #(.W(W)) u_add (
    .clk(clk), .rst(rst), .en(state == CALC), .a(op_a), .b(op_b), .sum(rsp_sum)
  );

  // One-hot operand mux driven by the arbiter grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  assign launch = (state == IDLE) && any;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        req_ready = grant;
        busy      = 1'b0;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands and id are captured only on the accept edge, so they stay put while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      id_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (launch) begin
      rr_ptr <= IDW'(wrap_inc(int'(grant_idx), N));
      id_q   <= grant_idx;
      op_a   <= sel_a;
      op_b   <= sel_b;
    end
  end

  assign rsp_id = id_q;
endmodule

// File: doc/add_rr_scheduler.md
Name: add_rr_scheduler

Overview:
- Shares one registered W-bit adder (1-cycle latency, sum wraps modulo 2^W) between N requesters.
- Round-robin arbiter picks one pending request, launches it into the adder, then presents the tagged result on a single response channel with backpressure.
- Sits between the client blocks and the adder datapath. It is the only driver of the adder's operand inputs.

Parameters:
- N, 4, number of requesters (≥2).
- W, 2, operand/sum width in bits.
- IDW, $clog2(N), requester-index width.

Ports:
- clk  in  1  system clock, all logic posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N  request pending, one bit per requester.
- req_a  in  N*W  operand A, requester i at bits [i*W +: W].
- req_b  in  N*W  operand B, same packing.
- req_ready  out  N  one-hot accept strobe; request i consumed when req_valid[i] && req_ready[i].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  W  (a + b) mod 2^W.
- rsp_id  out  IDW  index of the requester that issued the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clk edge with rst=1), all outputs:
  - req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0.
  - state=IDLE, rr_ptr=0.
  - Adder output register cleared.
- FSM states are IDLE, CALC and RESP.
- IDLE:
  - If any req_valid bit is set, grant g = the first set bit searching from rr_ptr upward, wrapping N-1 to 0.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0.
  - At the edge: capture req_a[g] and req_b[g] into the adder inputs, latch g, rr_ptr <= (g+1) mod N, go to CALC.
  - If no req_valid bit is set, stay in IDLE with rr_ptr unchanged.
- CALC:
  - The adder registers the sum on this edge.
  - Unconditionally go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id are held stable.
  - On rsp_valid && rsp_ready, go to IDLE at that edge.
  - Otherwise hold indefinitely; rsp_sum and rsp_id must not change while stalled.
- Latency:
  - Grant edge to rsp_valid high is 2 cycles.
  - Best-case throughput is 1 operation per 3 cycles.
  - No new grant is issued before the previous response is accepted. At most one operation is in flight.
- req_ready is asserted only in IDLE and only toward a requester with req_valid=1. It is never multi-hot.
- Requesters must hold valid and operands until accepted. The block samples operands only on the accept edge.
- Wrap-around:
  - Sum overflow is discarded (e.g. W=2: 3+3=2). No carry output.
  - rr_ptr wraps from N-1 to 0.
- Simultaneous events:
  - rsp_ready accepted in RESP returns to IDLE. A pending request is granted in the following cycle, not the same one.
  - rst has priority over every transition.
- Reset mid-operation (CALC or RESP): the operation is dropped and no response is produced. The requester already saw its accept.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0. No requester waits more than N grants.

Decomposition:
- Shared package add_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, RESP} sched_state_t;
  - localparam default widths.
- One natural sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req, ptr.
  - Outputs: one-hot grant, encoded grant index, any.
  - Purely combinational.
- The scheduler instantiates rr_arbiter and the registered adder. The adder's synchronous reset is tied to rst.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release with req_valid=0 → all outputs 0, busy=0 for 10 cycles.
- Single request: req_valid=4'b0100, a2=1, b2=2 → req_ready=4'b0100 for 1 cycle; rsp_valid high 2 cycles later with rsp_sum=3 and rsp_id=2; rsp_ready=1 returns busy=0 the next cycle.
- Overflow (W=2): requester 0 sends a=3, b=3 → rsp_sum=2, rsp_id=0. Requester 1 sends a=2, b=3 → rsp_sum=1.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0 with a grant every 3 cycles; then only requesters 1 and 3 valid with rr_ptr=2 → grants 3,1,3.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid stays 1 with sum/id stable, req_ready=0 throughout although other requests are pending; raising rsp_ready completes the handshake.
- Reset mid-operation: assert rst in CALC → no rsp_valid afterwards, rr_ptr=0, and the next grant goes to the lowest-index valid requester.
